// File: rtl/dac_wavegen.sv
// Waveform source for the MCP4725 DAC interface: hold, sawtooth, triangle or square
// samples at a programmable rate, delivered through a busy-aware one-cycle update strobe.
module dac_wavegen #(
    parameter int WIDTH  = 12,
    parameter int STEP_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [DIV_W-1:0]  div,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [WIDTH-1:0]  hold_val,
    input  logic              dac_busy,
    output logic [WIDTH-1:0]  dac_val,
    output logic              dac_upd,
    output logic              wrap,
    output logic              overrun
);
    localparam int XW = WIDTH + 1;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_SAW  = 2'd1,
        MODE_TRI  = 2'd2,
        MODE_SQR  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [WIDTH-1:0] acc, acc_nx, samp, pend_val;
    logic [DIV_W-1:0] div_cnt;
    logic             pend, first, tick, mode_chg, wrap_nx;
    dir_t             dir, dir_nx;
    mode_t            mode_q, mode_cur;
    logic [XW-1:0]    lo_x, hi_x, acc_x, step_x, sum_x, lo_step_x, diff_x;

    always_comb begin
        lo_x      = XW'(lo);
        hi_x      = XW'(hi);
        acc_x     = XW'(acc);
        step_x    = XW'(step);
        sum_x     = acc_x + step_x;
        lo_step_x = lo_x + step_x;
        diff_x    = acc_x - step_x;
        mode_cur  = mode_t'(mode);
        mode_chg  = (mode_cur != mode_q);
        tick      = en && !mode_chg && (div_cnt >= div);

        samp    = acc;
        acc_nx  = acc;
        dir_nx  = dir;
        wrap_nx = 1'b0;
        if (first) begin
            samp   = (mode_q == MODE_HOLD) ? hold_val : lo;
            acc_nx = lo;
            dir_nx = DIR_UP;
        end else if (mode_q == MODE_HOLD) begin
            samp = hold_val;
        end else if (lo_x >= hi_x) begin
            samp   = lo;
            acc_nx = lo;
        end else begin
            case (mode_q)
                MODE_SAW: begin
                    if (sum_x > hi_x) begin
                        acc_nx  = lo;
                        wrap_nx = 1'b1;
                    end else begin
                        acc_nx = sum_x[WIDTH-1:0];
                    end
                    samp = acc_nx;
                end
                MODE_TRI: begin
                    if (dir == DIR_UP) begin
                        if (sum_x >= hi_x) begin
                            acc_nx = hi;
                            dir_nx = DIR_DOWN;
                        end else begin
                            acc_nx = sum_x[WIDTH-1:0];
                        end
                    end else if (acc_x <= lo_step_x) begin
                        acc_nx  = lo;
                        dir_nx  = DIR_UP;
                        wrap_nx = 1'b1;
                    end else begin
                        acc_nx = diff_x[WIDTH-1:0];
                    end
                    samp = acc_nx;
                end
                default: begin
                    // dir doubles as square phase: DIR_UP means the next sample is hi
                    if (dir == DIR_UP) begin
                        samp   = hi;
                        dir_nx = DIR_DOWN;
                    end else begin
                        samp    = lo;
                        dir_nx  = DIR_UP;
                        wrap_nx = 1'b1;
                    end
                    acc_nx = samp;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            dir      <= DIR_UP;
            div_cnt  <= '0;
            first    <= 1'b1;
            mode_q   <= MODE_HOLD;
        end else begin
            mode_q <= mode_cur;
            if (!en || mode_chg) begin
                div_cnt <= '0;
                first   <= 1'b1;
                if (mode_chg) dir <= DIR_UP;
            end else if (tick) begin
                div_cnt <= '0;
                first   <= 1'b0;
                acc     <= acc_nx;
                dir     <= dir_nx;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // A tick with the DAC free bypasses the pending slot; overrun only flags
    // a pending sample that was overwritten while the DAC was still busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= 1'b0;
            pend_val <= '0;
            dac_val  <= '0;
            dac_upd  <= 1'b0;
            wrap     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            dac_upd <= 1'b0;
            overrun <= 1'b0;
            wrap    <= tick && wrap_nx;
            if (tick && !dac_busy) begin
                dac_val <= samp;
                dac_upd <= 1'b1;
                pend    <= 1'b0;
            end else if (tick) begin
                pend_val <= samp;
                pend     <= 1'b1;
                overrun  <= pend;
            end else if (!en) begin
                pend <= 1'b0;
            end else if (pend && !dac_busy) begin
                dac_val <= pend_val;
                dac_upd <= 1'b1;
                pend    <= 1'b0;
            end
        end
    end
endmodule
